// File: rtl/result_router_if.sv
// Result router handshake bundle: input stream, matched channels, monitor.
// The DUT takes the slave side; the producer/consumer side is master.
interface result_router_if #(
  parameter int WIDTH = 5,
  parameter int NCH   = 2
);
  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 enable;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [WIDTH-1:0]     mon_data;
  logic                 mon_valid;
  logic                 mon_ready;

  modport master (
    output in_data, in_valid, enable,
    output out_ready, mon_ready,
    input  in_ready, out_data, out_valid,
    input  mon_data, mon_valid
  );

  modport slave (
    input  in_data, in_valid, enable,
    input  out_ready, mon_ready,
    output in_ready, out_data, out_valid,
    output mon_data, mon_valid
  );
endinterface

// File: rtl/result_router.sv
// Routes result words to the channel whose code (2*i+1) they match,
// mirrors every accepted word to a monitor slot, and keeps statistics.
module result_router #(
  parameter int WIDTH = 5,
  parameter int NCH   = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  result_router_if.slave       bus,
  output logic [NCH*CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0]     drop_count
);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [NCH-1:0]   match;
  logic [NCH-1:0]   tgt;
  logic [NCH-1:0]   ch_free;
  logic [NCH-1:0]   ch_hs;
  logic [NCH-1:0]   ch_load;
  logic [NCH-1:0]   ch_v;
  logic [WIDTH-1:0] ch_q [NCH];
  logic [CNT_W-1:0] hits [NCH];
  logic [WIDTH-1:0] mon_q;
  logic             mon_v;
  logic [CNT_W-1:0] drops;
  logic             mon_free;
  logic             tgt_ok;
  logic             acc;
  logic             drop;

  always_comb begin
    match   = '0;
    tgt     = '0;
    ch_free = '0;
    ch_hs   = '0;
    for (int i = 0; i < NCH; i++) begin
      match[i]   = bus.in_data == WIDTH'(2*i+1);
      tgt[i]     = match[i] && bus.enable;
      ch_free[i] = !ch_v[i] || bus.out_ready[i];
      ch_hs[i]   = ch_v[i] && bus.out_ready[i];
    end
  end

  // a slot that is draining this cycle may be refilled at the same edge
  assign tgt_ok       = &(~tgt | ch_free);
  assign mon_free     = !mon_v || bus.mon_ready;
  assign bus.in_ready = !rst && mon_free && tgt_ok;
  assign acc          = bus.in_valid && bus.in_ready;
  assign ch_load      = tgt & {NCH{acc}};
  assign drop         = acc && !bus.enable && |match;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_v  <= '0;
      mon_v <= 1'b0;
      mon_q <= '0;
      drops <= '0;
      for (int i = 0; i < NCH; i++) begin
        ch_q[i] <= '0;
        hits[i] <= '0;
      end
    end else begin
      if (acc) begin
        mon_v <= 1'b1;
        mon_q <= bus.in_data;
      end else if (bus.mon_ready) begin
        mon_v <= 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_load[i]) begin
          ch_v[i] <= 1'b1;
          ch_q[i] <= bus.in_data;
        end else if (bus.out_ready[i]) begin
          ch_v[i] <= 1'b0;
        end
        if (ch_hs[i] && hits[i] != CMAX)
          hits[i] <= hits[i] + 1'b1;
      end
      if (drop && drops != CMAX)
        drops <= drops + 1'b1;
    end
  end

  always_comb begin
    bus.out_data = '0;
    hit_count    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_v[i])
        bus.out_data[i*WIDTH +: WIDTH] = ch_q[i];
      hit_count[i*CNT_W +: CNT_W] = hits[i];
    end
  end

  assign bus.out_valid = ch_v;
  assign bus.mon_valid = mon_v;
  assign bus.mon_data  = mon_v ? mon_q : '0;
  assign drop_count    = drops;
endmodule

// File: tb/tb_result_router.sv
// Self-checking bench for result_router: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_result_router;
  localparam int W = 5;
  localparam int N = 2;
  localparam int C = 8;

  logic clk;
  logic rst;
  logic [N*C-1:0] hc;
  logic [C-1:0]   dc;
  logic [N*2-1:0] hc2;
  logic [1:0]     dc2;
  int checks;
  int errors;

  result_router_if #(.WIDTH(W), .NCH(N)) ifa ();
  result_router_if #(.WIDTH(W), .NCH(N)) ifb ();

  result_router #(.WIDTH(W), .NCH(N), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .bus(ifa),
    .hit_count(hc), .drop_count(dc)
  );

  result_router #(.WIDTH(W), .NCH(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(ifb),
    .hit_count(hc2), .drop_count(dc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.in_valid  = 1'b0;
    ifa.out_ready = '1;
    ifa.mon_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_data = 5'd1;
    ifa.enable = 1'b1; ifa.out_ready = '1; ifa.mon_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0;
    ifb.enable = 1'b0; ifb.out_ready = '1; ifb.mon_ready = 1'b1;
    tick();
    tick();
    #2;
    checks++;
    if (ifa.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=0", ifa.in_ready);
    end
    checks++;
    if (ifa.out_valid !== 2'b00 || ifa.mon_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b/%b exp=00/0",
               ifa.out_valid, ifa.mon_valid);
    end
    checks++;
    if (hc !== '0 || dc !== '0 || hc2 !== '0) begin
      errors++;
      $display("FAIL reset_counts got=%h/%h/%h exp=0", hc, dc, hc2);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_routing();
    ifa.in_valid = 1'b1; ifa.in_data = 5'd1; ifa.enable = 1'b1;
    #2;
    checks++;
    if (ifa.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL route_ready got=%b exp=1", ifa.in_ready);
    end
    tick();
    ifa.in_valid = 1'b0;
    checks++;
    if (ifa.out_valid !== 2'b01 || ifa.out_data[4:0] !== 5'd1) begin
      errors++;
      $display("FAIL route_out got=%b/%0d exp=01/1",
               ifa.out_valid, ifa.out_data[4:0]);
    end
    checks++;
    if (ifa.mon_valid !== 1'b1 || ifa.mon_data !== 5'd1) begin
      errors++;
      $display("FAIL route_mon got=%b/%0d exp=1/1",
               ifa.mon_valid, ifa.mon_data);
    end
    tick();
    checks++;
    if (hc[7:0] !== 8'd1 || ifa.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL route_hit got=%0d/%b exp=1/00",
               hc[7:0], ifa.out_valid);
    end
    checks++;
    if (ifa.out_data !== '0 || ifa.mon_data !== '0) begin
      errors++;
      $display("FAIL route_zero got=%h/%h exp=0/0",
               ifa.out_data, ifa.mon_data);
    end
    idle();
  endtask

  task automatic test_suppress();
    ifa.in_valid = 1'b1; ifa.in_data = 5'd3; ifa.enable = 1'b0;
    tick();
    ifa.in_valid = 1'b0;
    checks++;
    if (ifa.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL supp_out got=%b exp=00", ifa.out_valid);
    end
    checks++;
    if (ifa.mon_valid !== 1'b1 || ifa.mon_data !== 5'd3) begin
      errors++;
      $display("FAIL supp_mon got=%b/%0d exp=1/3",
               ifa.mon_valid, ifa.mon_data);
    end
    checks++;
    if (dc !== 8'd1) begin
      errors++;
      $display("FAIL supp_drop got=%0d exp=1", dc);
    end
    idle();
  endtask

  task automatic test_backpressure();
    ifa.out_ready = 2'b01; ifa.enable = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_data = 5'd3;
    tick();
    #2;
    checks++;
    if (ifa.in_ready !== 1'b0 || ifa.out_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_block got=%b/%b exp=0/1",
               ifa.in_ready, ifa.out_valid[1]);
    end
    tick();
    checks++;
    if (ifa.out_data[9:5] !== 5'd3 || ifa.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got=%0d/%b exp=3/0",
               ifa.out_data[9:5], ifa.in_ready);
    end
    ifa.out_ready = 2'b11;
    #2;
    checks++;
    if (ifa.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got=%b exp=1", ifa.in_ready);
    end
    tick();
    ifa.in_valid = 1'b0;
    checks++;
    if (ifa.out_valid[1] !== 1'b1 || hc[15:8] !== 8'd1) begin
      errors++;
      $display("FAIL bp_refill got=%b/%0d exp=1/1",
               ifa.out_valid[1], hc[15:8]);
    end
    tick();
    checks++;
    if (hc[15:8] !== 8'd2 || ifa.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL bp_hits got=%0d/%b exp=2/00",
               hc[15:8], ifa.out_valid);
    end
    idle();
  endtask

  task automatic test_unmatched();
    logic [N*C-1:0] hc_s;
    logic [C-1:0]   dc_s;
    hc_s = hc;
    dc_s = dc;
    ifa.in_valid = 1'b1; ifa.in_data = 5'd5; ifa.enable = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    checks++;
    if (ifa.mon_data !== 5'd5 || ifa.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL unm_route got=%0d/%b exp=5/00",
               ifa.mon_data, ifa.out_valid);
    end
    tick();
    checks++;
    if (hc !== hc_s || dc !== dc_s) begin
      errors++;
      $display("FAIL unm_counts got=%h/%h exp=%h/%h",
               hc, dc, hc_s, dc_s);
    end
    ifa.mon_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 5'd5;
    tick();
    for (int k = 0; k < 64; k++) begin
      ifa.in_data = 5'(k % 32);
      ifa.enable = (k >= 32);
      #2;
      checks++;
      if (ifa.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL mon_block d=%0d e=%0d got=%b exp=0",
                 k % 32, k / 32, ifa.in_ready);
      end
      tick();
    end
    checks++;
    if (ifa.mon_valid !== 1'b1 || ifa.mon_data !== 5'd5) begin
      errors++;
      $display("FAIL mon_hold got=%b/%0d exp=1/5",
               ifa.mon_valid, ifa.mon_data);
    end
    idle();
  endtask

  task automatic test_saturation();
    ifb.in_valid = 1'b1; ifb.in_data = 5'd1; ifb.enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) ifb.in_valid = 1'b0;
      tick();
      checks++;
      if (int'(hc2[1:0]) !== ((k - 1 > 3) ? 3 : k - 1)) begin
        errors++;
        $display("FAIL sat_hit k=%0d got=%0d exp=%0d",
                 k, hc2[1:0], (k - 1 > 3) ? 3 : k - 1);
      end
    end
    tick();
    checks++;
    if (hc2[1:0] !== 2'd3 || hc2[3:2] !== 2'd0) begin
      errors++;
      $display("FAIL sat_final got=%0d/%0d exp=3/0",
               hc2[1:0], hc2[3:2]);
    end
  endtask

  task automatic test_reset_mid();
    ifa.out_ready = 2'b00; ifa.mon_ready = 1'b1; ifa.enable = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_data = 5'd1;
    tick();
    ifa.in_data = 5'd3;
    tick();
    ifa.in_data = 5'd1;
    #2;
    checks++;
    if (ifa.out_valid !== 2'b11) begin
      errors++;
      $display("FAIL mid_pending got=%b exp=11", ifa.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ifa.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready got=%b exp=0", ifa.in_ready);
    end
    tick();
    checks++;
    if (ifa.out_valid !== 2'b00 || ifa.mon_valid !== 1'b0 ||
        ifa.out_data !== '0) begin
      errors++;
      $display("FAIL mid_clear got=%b/%b/%h exp=00/0/0",
               ifa.out_valid, ifa.mon_valid, ifa.out_data);
    end
    checks++;
    if (hc !== '0 || dc !== '0 || hc2 !== '0) begin
      errors++;
      $display("FAIL mid_counts got=%h/%h/%h exp=0", hc, dc, hc2);
    end
    rst = 1'b0;
    ifa.out_ready = 2'b11;
    #2;
    checks++;
    if (ifa.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_first got=%b exp=1", ifa.in_ready);
    end
    tick();
    ifa.in_valid = 1'b0;
    checks++;
    if (ifa.out_valid !== 2'b01 || ifa.mon_data !== 5'd1) begin
      errors++;
      $display("FAIL mid_accept got=%b/%0d exp=01/1",
               ifa.out_valid, ifa.mon_data);
    end
    idle();
  endtask

  task automatic test_random();
    bit         m_val [N];
    int         m_dat [N];
    int         m_hit [N];
    bit         m_mv;
    int         m_md;
    int         m_drop;
    int         tgt;
    bit         matched;
    bit         exp_rdy;
    logic [N*W-1:0] exp_od;
    logic [N*C-1:0] exp_hc;
    logic [N-1:0]   exp_ov;
    rst = 1'b1;
    ifa.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_val[i] = 0; m_dat[i] = 0; m_hit[i] = 0;
    end
    m_mv = 0; m_md = 0; m_drop = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case ($urandom_range(0, 3))
        0: ifa.in_data = 5'd1;
        1: ifa.in_data = 5'd3;
        default: ifa.in_data = 5'($urandom_range(0, 31));
      endcase
      ifa.in_valid  = $urandom_range(0, 3) != 0;
      ifa.enable    = $urandom_range(0, 3) != 0;
      ifa.out_ready = 2'($urandom_range(0, 3));
      ifa.mon_ready = $urandom_range(0, 3) != 0;
      #2;
      tgt = -1;
      matched = 0;
      for (int i = 0; i < N; i++) begin
        if (int'(ifa.in_data) == 2*i+1) begin
          matched = 1;
          if (ifa.enable) tgt = i;
        end
      end
      exp_rdy = (!m_mv || ifa.mon_ready) &&
                (tgt < 0 || !m_val[tgt] || ifa.out_ready[tgt]);
      exp_od = '0;
      exp_hc = '0;
      exp_ov = '0;
      for (int i = 0; i < N; i++) begin
        exp_ov[i] = m_val[i];
        if (m_val[i]) exp_od[i*W +: W] = W'(m_dat[i]);
        exp_hc[i*C +: C] = C'(m_hit[i]);
      end
      checks++;
      if (ifa.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b",
                 cyc, ifa.in_ready, exp_rdy);
      end
      checks++;
      if (ifa.out_valid !== exp_ov || ifa.out_data !== exp_od) begin
        errors++;
        $display("FAIL rnd_out cyc=%0d got=%b/%h exp=%b/%h",
                 cyc, ifa.out_valid, ifa.out_data, exp_ov, exp_od);
      end
      checks++;
      if (ifa.mon_valid !== m_mv ||
          ifa.mon_data !== (m_mv ? W'(m_md) : W'(0))) begin
        errors++;
        $display("FAIL rnd_mon cyc=%0d got=%b/%0d exp=%b/%0d",
                 cyc, ifa.mon_valid, ifa.mon_data, m_mv, m_md);
      end
      checks++;
      if (hc !== exp_hc || int'(dc) !== m_drop) begin
        errors++;
        $display("FAIL rnd_counts cyc=%0d got=%h/%0d exp=%h/%0d",
                 cyc, hc, dc, exp_hc, m_drop);
      end
      for (int i = 0; i < N; i++) begin
        if (m_val[i] && ifa.out_ready[i]) begin
          m_val[i] = 0;
          if (m_hit[i] < 255) m_hit[i]++;
        end
      end
      if (m_mv && ifa.mon_ready) m_mv = 0;
      if (ifa.in_valid && exp_rdy) begin
        m_mv = 1;
        m_md = int'(ifa.in_data);
        if (tgt >= 0) begin
          m_val[tgt] = 1;
          m_dat[tgt] = int'(ifa.in_data);
        end else if (matched && m_drop < 255) begin
          m_drop++;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_routing();
    test_suppress();
    test_backpressure();
    test_unmatched();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
